md5_block_engine: RTL and testbench
===================================

# md5_block_engine

Parametrised iterative MD5 compression engine, the next generation of our single-block MD5 core. It accepts pre-padded 512-bit message blocks over a valid/ready handshake and chains the hash state across multi-block messages. It computes a configurable number of MD5 steps per clock and returns the 128-bit digest over a second valid/ready handshake. It sits between the message padder/packer and the digest consumer in the hashing datapath.

## Interface
- STEPS_PER_CYCLE, 1, MD5 steps per clock; legal values 1, 2 and 4; any other value is an elaboration `$error`.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- blk_valid_i  in  1  block offered.
- blk_ready_o  out  1  engine accepts a block this cycle.
- blk_i  in  512  message block; word M[w] = blk_i[32w+31:32w].
- first_i  in  1  block starts a new message; chain loads IV. Qualified by the block handshake.
- last_i  in  1  block ends the message; digest is emitted. Qualified by the block handshake.
- dig_valid_o  out  1  digest available.
- dig_ready_i  in  1  consumer takes the digest.
- digest_o  out  128  {D,C,B,A}, with A in [31:0].
- busy_o  out  1  high in RUN and ADD.

## Operation
- State machine states: IDLE, RUN, ADD, DONE. Reset state is IDLE.
- **IDLE**
  - blk_ready_o=1.
  - On blk_valid_i&blk_ready_o: latch M[0..15] and last_i.
  - Working {A,B,C,D} is loaded with IV if first_i=1, otherwise with the chain register.
  - The chain register is also loaded with IV when first_i=1.
  - step counter is cleared to 0; next state RUN.
- **RUN**
  - Each cycle applies STEPS_PER_CYCLE consecutive steps, chained combinationally.
  - Each step uses the standard F/G/H/I function, message index, K[j] and shift s[j] for its step number j.
  - After each cycle, counter += STEPS_PER_CYCLE.
  - After the cycle that processes step 63, next state is ADD.
- **ADD**
  - chain[x] <= chain[x] + work[x], per 32-bit word, mod 2^32; carries are discarded.
  - If the latched last=1: digest_o <= new chain and the next state is DONE. Otherwise the next state is IDLE.
- **DONE**
  - dig_valid_o=1 and blk_ready_o=0.
  - digest_o is held stable until dig_valid_o&dig_ready_i; next state is then IDLE.
  - The chain register is not cleared; the next message must assert first_i.
- IV: A=0x67452301, B=0xefcdab89, C=0x98badcfe, D=0x10325476.
- The chain register resets to IV, so a block with first_i=0 arriving right after reset is treated as a message start.
- first_i=last_i=1 on the same block is a single-block message.
- blk_valid_i outside IDLE is ignored; blk_i may change freely while ready is low.
- Reset mid-operation immediately forces the following: IDLE; chain=IV; working=0; digest_o=0; dig_valid_o=0. The interrupted block and any pending digest are lost.

## Timing
- Reset values:
  - blk_ready_o=0 during reset, then 1 in IDLE.
  - dig_valid_o=0, busy_o=0, digest_o=0.
- Let N = 64/STEPS_PER_CYCLE, giving 64, 32 or 16 RUN cycles.
- Latency: dig_valid_o rises N+1 rising edges after the accepting edge, i.e. 65, 33 or 17.
- Throughput: one block per N+2 cycles for non-last blocks. A last block additionally needs at least 1 DONE cycle.
- If dig_ready_i is already high when dig_valid_o rises, the digest is consumed in that same cycle. IDLE follows on the next edge.
- blk_ready_o is a registered function of state only; it has no combinational path from blk_valid_i.

## Configuration
- `MD5_BSWAP_EN` defined:
  - Each input word is byte-reversed before use, for big-endian byte streams.
  - Each 32-bit digest word is byte-reversed at digest_o.
- Not defined: words are used as-is (native MD5 little-endian) and digest_o is unswapped.
- The macro has no effect on latency.

## Structure
- md5_pkg holds:
  - K[0:63] table;
  - shift table s[0:63];
  - IV constants;
  - state enum typedef (IDLE/RUN/ADD/DONE);
  - message-index function g(j);
  - round-function function.
- Sub-module md5_step: combinational single step, taking (A,B,C,D,M,j) and producing the next (A,B,C,D). It is instantiated STEPS_PER_CYCLE times in a generate chain.
- The engine holds all registers, the FSM and both handshakes.

## Test plan
- **Empty string:** blk_i with M[0]=0x00000080, rest 0, first=last=1, STEPS_PER_CYCLE=1.
  - Required digest_o[31:0]=0xd98c1dd4, [63:32]=0x04b2008f, [95:64]=0x980980e9, [127:96]=0x7e42f8ec.
  - dig_valid_o rises 65 edges after the accept edge.
- **"abc":** M[0]=0x80636261, M[14]=0x00000018, first=last=1.
  - Required digest_o[31:0]=0x98500190 (d41d8c… variant check via the golden model for the remaining words).
  - Repeat with STEPS_PER_CYCLE=2 and 4: identical digest, latency 33 and 17.
- **Two-block message:** first block first=1/last=0, second block first=0/last=1.
  - No dig_valid_o after block 1.
  - blk_ready_o returns high N+2 cycles after the first accept.
  - Final digest matches the golden model.
- **Backpressure:** hold dig_ready_i=0 for 10 cycles after dig_valid_o.
  - digest_o stays stable and blk_ready_o=0 throughout.
  - Release: one handshake, then IDLE with blk_ready_o=1.
- **Reset mid-RUN:** pull rst_i low at step ~30.
  - Outputs go to reset values asynchronously.
  - After release, the empty-string block gives the same digest as the empty-string scenario.
- **`MD5_BSWAP_EN` build:** empty-string block fed byte-swapped (M[0]=0x80000000).
  - digest_o[31:0]=0xd41d8cd9.

Source files
------------

// File: rtl/md5_pkg.sv
// MD5 constants and helpers shared by the block engine and its step datapath.
// Holds the K[0:63] additive constants, the per-step rotate amounts s[0:63],
// the initial chaining value, the engine state type, the message-word index
// function g(j) and the round function F/G/H/I.
// No ports. Optional build macro MD5_BSWAP_EN is consumed by md5_block_engine.
package md5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_ADD,
    ST_DONE
  } md5_state_e;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] MD5_K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] MD5_S [64] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  // Message word used by step j; all arithmetic is naturally mod 16.
  function automatic logic [3:0] md5_msg_idx(input logic [5:0] j);
    logic [3:0] jl;
    logic [3:0] idx;
    jl = j[3:0];
    case (j[5:4])
      2'd0:    idx = jl;
      2'd1:    idx = 4'd5 * jl + 4'd1;
      2'd2:    idx = 4'd3 * jl + 4'd5;
      default: idx = 4'd7 * jl;
    endcase
    return idx;
  endfunction

  function automatic logic [31:0] md5_round_fn(input logic [5:0] j,
                                               input logic [31:0] b,
                                               input logic [31:0] c,
                                               input logic [31:0] d);
    logic [31:0] f;
    case (j[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    return f;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/md5_block_engine_if.sv
// Block-in / digest-out handshake bundle of md5_block_engine.
//   blk_valid_i/blk_ready_o : block handshake, blk_i 512-bit block, first_i/last_i flags
//   dig_valid_o/dig_ready_i : digest handshake, digest_o {D,C,B,A}
//   busy_o                  : engine is compressing
// Signal suffixes are from the engine's point of view; the engine uses the
// slave modport, the padder/consumer side uses master.
interface md5_block_engine_if;
  logic         blk_valid_i;
  logic         blk_ready_o;
  logic [511:0] blk_i;
  logic         first_i;
  logic         last_i;
  logic         dig_valid_o;
  logic         dig_ready_i;
  logic [127:0] digest_o;
  logic         busy_o;

  modport slave (
    input  blk_valid_i, blk_i, first_i, last_i, dig_ready_i,
    output blk_ready_o, dig_valid_o, digest_o, busy_o
  );

  modport master (
    output blk_valid_i, blk_i, first_i, last_i, dig_ready_i,
    input  blk_ready_o, dig_valid_o, digest_o, busy_o
  );
endinterface

// File: rtl/md5_step.sv
// One combinational MD5 step j applied to working state (A,B,C,D).
//   a_in..d_in : working state before the step
//   msg        : 16-word block, word w at [32w+31:32w]
//   j          : step number 0..63
//   a_out..d_out : working state after the step
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [511:0] msg,
  input  logic [5:0]   j,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out
);

  logic [31:0] m_word;
  logic [31:0] sum;
  logic [63:0] rot;

  always_comb begin
    m_word = msg[{md5_msg_idx(j), 5'b00000} +: 32];
    sum    = a_in + md5_round_fn(j, b_in, c_in, d_in) + MD5_K[j] + m_word;
    // Upper half of the doubled word shifted left is the 32-bit rotate-left.
    rot    = {sum, sum} << MD5_S[j];
    a_out  = d_in;
    b_out  = b_in + rot[63:32];
    c_out  = b_in;
    d_out  = c_in;
  end

endmodule

// File: rtl/md5_block_engine.sv
// Iterative MD5 compression engine with hash chaining across blocks.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : md5_block_engine_if.slave (block in, digest out, busy)
// STEPS_PER_CYCLE (1, 2 or 4) md5_step instances are chained per clock.
// Build macro MD5_BSWAP_EN: byte-reverse each message word on input and each
// digest word on output, for big-endian byte streams.
//
// state   | meaning
// IDLE    | ready for a block; accept loads message and working state
// RUN     | STEPS_PER_CYCLE steps per clock until step 63 is done
// ADD     | fold working state into chain; publish digest on last block
// DONE    | digest valid, held until the consumer takes it
module md5_block_engine
  import md5_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  md5_block_engine_if.slave bus
);

  if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4)) begin : g_bad_spc
    $error("md5_block_engine: STEPS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [5:0] LAST_CNT = 6'(64 - STEPS_PER_CYCLE);
  localparam logic [5:0] CNT_INC  = 6'(STEPS_PER_CYCLE);

  md5_state_e   state, state_nxt;
  logic         ready_q;
  logic         blk_fire;
  logic [5:0]   step_cnt;
  logic [511:0] msg_in, msg_q;
  logic         last_q;
  logic [31:0]  work_a, work_b, work_c, work_d;
  logic [31:0]  chain_a, chain_b, chain_c, chain_d;
  logic [127:0] dig_q;

  logic [31:0] sa [STEPS_PER_CYCLE+1];
  logic [31:0] sb [STEPS_PER_CYCLE+1];
  logic [31:0] sc [STEPS_PER_CYCLE+1];
  logic [31:0] sd [STEPS_PER_CYCLE+1];

  // ready_q is only ever high in IDLE, so it also qualifies the accept.
  assign blk_fire = bus.blk_valid_i & ready_q;

  always_comb begin
    msg_in = '0;
    for (int w = 0; w < 16; w++) begin
`ifdef MD5_BSWAP_EN
      msg_in[32*w +: 32] = bswap32(bus.blk_i[32*w +: 32]);
`else
      msg_in[32*w +: 32] = bus.blk_i[32*w +: 32];
`endif
    end
  end

  assign sa[0] = work_a;
  assign sb[0] = work_b;
  assign sc[0] = work_c;
  assign sd[0] = work_d;

  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    md5_step u_step (
      .a_in  (sa[i]),
      .b_in  (sb[i]),
      .c_in  (sc[i]),
      .d_in  (sd[i]),
      .msg   (msg_q),
      .j     (step_cnt + 6'(i)),
      .a_out (sa[i+1]),
      .b_out (sb[i+1]),
      .c_out (sc[i+1]),
      .d_out (sd[i+1])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (blk_fire) state_nxt = ST_RUN;
      ST_RUN:  if (step_cnt == LAST_CNT) state_nxt = ST_ADD;
      ST_ADD:  state_nxt = last_q ? ST_DONE : ST_IDLE;
      ST_DONE: if (bus.dig_ready_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      step_cnt <= '0;
      msg_q    <= '0;
      last_q   <= 1'b0;
      work_a   <= '0;
      work_b   <= '0;
      work_c   <= '0;
      work_d   <= '0;
      chain_a  <= IV_A;
      chain_b  <= IV_B;
      chain_c  <= IV_C;
      chain_d  <= IV_D;
      dig_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (blk_fire) begin
            msg_q    <= msg_in;
            last_q   <= bus.last_i;
            step_cnt <= '0;
            if (bus.first_i) begin
              work_a  <= IV_A;
              work_b  <= IV_B;
              work_c  <= IV_C;
              work_d  <= IV_D;
              chain_a <= IV_A;
              chain_b <= IV_B;
              chain_c <= IV_C;
              chain_d <= IV_D;
            end else begin
              work_a <= chain_a;
              work_b <= chain_b;
              work_c <= chain_c;
              work_d <= chain_d;
            end
          end
        end
        ST_RUN: begin
          work_a   <= sa[STEPS_PER_CYCLE];
          work_b   <= sb[STEPS_PER_CYCLE];
          work_c   <= sc[STEPS_PER_CYCLE];
          work_d   <= sd[STEPS_PER_CYCLE];
          step_cnt <= step_cnt + CNT_INC;
        end
        ST_ADD: begin
          chain_a <= chain_a + work_a;
          chain_b <= chain_b + work_b;
          chain_c <= chain_c + work_c;
          chain_d <= chain_d + work_d;
          if (last_q) begin
            dig_q <= {chain_d + work_d, chain_c + work_c, chain_b + work_b, chain_a + work_a};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.blk_ready_o = ready_q;
  assign bus.dig_valid_o = (state == ST_DONE);
  assign bus.busy_o      = (state == ST_RUN) || (state == ST_ADD);

`ifdef MD5_BSWAP_EN
  assign bus.digest_o = {bswap32(dig_q[127:96]), bswap32(dig_q[95:64]),
                         bswap32(dig_q[63:32]), bswap32(dig_q[31:0])};
`else
  assign bus.digest_o = dig_q;
`endif

endmodule

// File: tb/tb_md5_block_engine.sv
// Bench for md5_block_engine: three instances (1, 2 and 4 steps per cycle)
// share one stimulus. Expected digests are published MD5 values of known
// strings; blocks are padded by the bench from the ASCII message.
module tb_md5_block_engine;

  logic               clk;
  logic               rst;
  logic [2:0]         blk_valid;
  logic [511:0]       blk;
  logic               first;
  logic               last;
  logic               dig_ready;
  logic [2:0]         rdy, dv, busy;
  logic [2:0][127:0]  dig;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    md5_block_engine_if bus ();
    assign bus.blk_valid_i = blk_valid[gi];
    assign bus.blk_i       = blk;
    assign bus.first_i     = first;
    assign bus.last_i      = last;
    assign bus.dig_ready_i = dig_ready;
    assign rdy[gi]         = bus.blk_ready_o;
    assign dv[gi]          = bus.dig_valid_o;
    assign busy[gi]        = bus.busy_o;
    assign dig[gi]         = bus.digest_o;
    md5_block_engine #(.STEPS_PER_CYCLE(1 << gi)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc [3], acc_prev [3], acc_cnt [3], acc_snap [3];
  int rise_cyc [3], rise_cnt [3], rise_snap [3];
  logic [127:0] cap [3];
  logic [2:0] dv_prev;

  localparam logic [127:0] D_EMPTY = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
  localparam logic [127:0] D_A     = 128'h61267769_e299c331_a8b6f1c0_b975c10c;
  localparam logic [127:0] D_ABC   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;
  localparam logic [127:0] D_MSGD  = 128'hd061f1aa_312f5a52_8d93b77c_7d696bf9;
  localparam logic [127:0] D_80    = 128'h7ab60721_2eda49ac_55c9e32b_a2f4ed57;

  typedef struct {
    string        name;
    logic [511:0] blk;
    logic         first;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  function automatic logic [31:0] sw32(input logic [31:0] x);
`ifdef MD5_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  function automatic logic [127:0] ex(input logic [127:0] x);
    return {sw32(x[127:96]), sw32(x[95:64]), sw32(x[63:32]), sw32(x[31:0])};
  endfunction

  // Byte k of the MD5-padded form of s (0x80, zeros, 64-bit LE bit length).
  function automatic logic [7:0] msg_byte(input string s, input int k);
    int    len;
    int    plen;
    longint bits;
    len  = s.len();
    plen = ((len + 8) / 64 + 1) * 64;
    bits = longint'(len) * 8;
    if (k < len) return s[k];
    if (k == len) return 8'h80;
    if (k >= plen - 8) return 8'(bits >> (8 * (k - plen + 8)));
    return 8'h00;
  endfunction

  function automatic logic [511:0] msg_block(input string s, input int idx);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < 64; k++) b[8*k +: 8] = msg_byte(s, 64 * idx + k);
    for (int w = 0; w < 16; w++) b[32*w +: 32] = sw32(b[32*w +: 32]);
    return b;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [2:0] acc;
    acc = blk_valid & rdy;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        acc_prev[i]  = acc_cyc[i];
        acc_cyc[i]   = cyc;
        acc_cnt[i]++;
        blk_valid[i] = 1'b0;
      end
      if (dv[i] && !dv_prev[i]) begin
        rise_cyc[i] = cyc;
        rise_cnt[i]++;
        cap[i] = dig[i];
      end
    end
    dv_prev = dv;
  endtask

  task automatic send(input string tag, input logic [511:0] b, input logic f, input logic l);
    bit done;
    done = 1'b0;
    blk = b;
    first = f;
    last = l;
    acc_snap = acc_cnt;
    blk_valid = 3'b111;
    for (int t = 0; t < 200 && !done; t++) begin
      tick();
      done = (acc_cnt[0] > acc_snap[0]) && (acc_cnt[1] > acc_snap[1]) && (acc_cnt[2] > acc_snap[2]);
    end
    blk_valid = 3'b000;
    chk({tag, " accept"}, 128'(done), 128'(1));
  endtask

  task automatic snap_rise();
    rise_snap = rise_cnt;
  endtask

  task automatic wait_dig(input string tag);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      tick();
      done = (rise_cnt[0] > rise_snap[0]) && (rise_cnt[1] > rise_snap[1]) && (rise_cnt[2] > rise_snap[2]);
    end
    chk({tag, " digest arrives"}, 128'(done), 128'(1));
  endtask

  // Digest and accept-to-valid latency per instance, then same-cycle consume.
  task automatic check_result(input string tag, input logic [127:0] exp);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s digest spc%0d", tag, 1 << i), cap[i], exp);
      chk($sformatf("%s latency spc%0d", tag, 1 << i), 128'(rise_cyc[i] - acc_cyc[i]), 128'((64 >> i) + 1));
    end
    tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s consumed spc%0d", tag, 1 << i), 128'({dv[i], rdy[i]}), 128'(2'b01));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [4];
    string s80;

    vecs[0] = '{"empty", msg_block("", 0),               1'b1, 1'b1, ex(D_EMPTY)};
    vecs[1] = '{"a",     msg_block("a", 0),              1'b1, 1'b1, ex(D_A)};
    vecs[2] = '{"abc",   msg_block("abc", 0),            1'b1, 1'b1, ex(D_ABC)};
    vecs[3] = '{"msgd",  msg_block("message digest", 0), 1'b1, 1'b1, ex(D_MSGD)};

    rst = 1'b0;
    blk_valid = 3'b000;
    blk = '0;
    first = 1'b0;
    last = 1'b0;
    dig_ready = 1'b1;
    dv_prev = 3'b000;
    for (int i = 0; i < 3; i++) begin
      acc_cyc[i] = 0; acc_prev[i] = 0; acc_cnt[i] = 0;
      rise_cyc[i] = 0; rise_cnt[i] = 0; cap[i] = '0;
    end

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset flags spc%0d", 1 << i), 128'({rdy[i], dv[i], busy[i]}), 128'(3'b000));
      chk($sformatf("reset digest spc%0d", 1 << i), dig[i], 128'(0));
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("idle ready spc%0d", 1 << i), 128'(rdy[i]), 128'(1));

    // Block with first=0 straight after reset starts from IV.
    snap_rise();
    send("nofirst", msg_block("", 0), 1'b0, 1'b1);
    wait_dig("nofirst");
    check_result("nofirst", ex(D_EMPTY));

    for (int v = 0; v < 4; v++) begin
      snap_rise();
      send(vecs[v].name, vecs[v].blk, vecs[v].first, vecs[v].last);
      wait_dig(vecs[v].name);
      check_result(vecs[v].name, vecs[v].exp);
    end

    // Two-block message: 80 ASCII digits.
    s80 = "";
    for (int i = 0; i < 8; i++) s80 = {s80, "1234567890"};
    snap_rise();
    send("two1", msg_block(s80, 0), 1'b1, 1'b0);
    send("two2", msg_block(s80, 1), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("two accept gap spc%0d", 1 << i), 128'(acc_cyc[i] - acc_prev[i]), 128'((64 >> i) + 2));
    wait_dig("two");
    for (int i = 0; i < 3; i++)
      chk($sformatf("two single digest spc%0d", 1 << i), 128'(rise_cnt[i] - rise_snap[i]), 128'(1));
    check_result("two", ex(D_80));

    // Backpressure: digest held with ready low.
    dig_ready = 1'b0;
    snap_rise();
    send("bp", msg_block("abc", 0), 1'b1, 1'b1);
    wait_dig("bp");
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp digest spc%0d", 1 << i), cap[i], ex(D_ABC));
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < 3; i++)
        chk($sformatf("bp hold c%0d spc%0d", c, 1 << i), {dig[i][125:0], dv[i], rdy[i]},
            {cap[i][125:0], 2'b10});
    end
    dig_ready = 1'b1;
    snap_rise();
    tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp release spc%0d", 1 << i), 128'({dv[i], rdy[i]}), 128'(2'b01));
    tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp one handshake spc%0d", 1 << i), 128'(rise_cnt[i] - rise_snap[i]), 128'(0));

    // Asynchronous reset in the middle of RUN.
    snap_rise();
    send("rst", msg_block("", 0), 1'b1, 1'b1);
    repeat (29) tick();
    chk("busy mid run spc1", 128'(busy[0]), 128'(1));
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async reset flags spc%0d", 1 << i), 128'({rdy[i], dv[i], busy[i]}), 128'(3'b000));
      chk($sformatf("async reset digest spc%0d", 1 << i), dig[i], 128'(0));
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    snap_rise();
    send("after rst", msg_block("", 0), 1'b0, 1'b1);
    wait_dig("after rst");
    check_result("after rst", ex(D_EMPTY));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
